// File: rtl/mmio_router_if.sv
// Bus bundle between the CPU load/store port, the router and the device slaves.
// The slave modport is the router's view (it services CPU accesses and drives
// the device selects); the master modport is the surrounding environment.
interface mmio_router_if #(
  parameter int N_SLV  = 8,
  parameter int DATA_W = 32
);
  logic                    m_req;
  logic                    m_we;
  logic [31:0]             m_addr;
  logic [DATA_W-1:0]       m_wdata;
  logic [DATA_W/8-1:0]     m_wmask;
  logic                    m_ready;
  logic                    m_rvalid;
  logic [DATA_W-1:0]       m_rdata;
  logic                    m_err;
  logic [N_SLV-1:0]        s_sel;
  logic                    s_we;
  logic [31:0]             s_addr;
  logic [DATA_W-1:0]       s_wdata;
  logic [DATA_W/8-1:0]     s_wmask;
  logic [N_SLV-1:0]        s_ack;
  logic [N_SLV*DATA_W-1:0] s_rdata;
  logic [31:0]             err_addr;
  logic [7:0]              err_cnt;

  modport slave (
    input  m_req, m_we, m_addr, m_wdata, m_wmask, s_ack, s_rdata,
    output m_ready, m_rvalid, m_rdata, m_err,
    output s_sel, s_we, s_addr, s_wdata, s_wmask,
    output err_addr, err_cnt
  );

  modport master (
    output m_req, m_we, m_addr, m_wdata, m_wmask, s_ack, s_rdata,
    input  m_ready, m_rvalid, m_rdata, m_err,
    input  s_sel, s_we, s_addr, s_wdata, s_wmask,
    input  err_addr, err_cnt
  );
endinterface

// File: rtl/mmio_router.sv
// Memory-mapped I/O router: decodes an address ID field onto one of N_SLV
// device slaves, runs a select/ack handshake with an optional wait timeout,
// and returns a one-cycle registered response with bus-error diagnostics.
module mmio_router #(
  parameter int                      N_SLV   = 8,
  parameter int                      DATA_W  = 32,
  parameter int                      ID_LO   = 20,
  parameter int                      ID_W    = 4,
  parameter logic [N_SLV*ID_W-1:0]   SLV_ID  = 32'h87654321,
  parameter int                      TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  mmio_router_if.slave       bus
);

  localparam int MASK_W = DATA_W / 8;
  // Wait counter width; TIMEOUT values must fit in this many bits.
  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e              state_q, state_d;
  logic [N_SLV-1:0]    sel_q, sel_d;
  logic                we_q, we_d;
  logic [31:0]         addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   wmask_q, wmask_d;
  logic [CNT_W-1:0]    wait_q, wait_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [31:0]         errAddr_q, errAddr_d;
  logic [7:0]          errCnt_q, errCnt_d;

  logic [ID_W-1:0]     reqId;
  logic                decHit;
  logic [N_SLV-1:0]    decSel;
  logic                ackHit;
  logic [DATA_W-1:0]   selRdata;
  logic [CNT_W-1:0]    waitInc;
  logic [7:0]          errCntInc;

  // Address decode; scanning from the top down lets the lowest matching slot win.
  always_comb begin
    reqId  = bus.m_addr[ID_LO +: ID_W];
    decHit = 1'b0;
    decSel = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (SLV_ID[i*ID_W +: ID_W] == reqId) begin
        decSel    = '0;
        decSel[i] = 1'b1;
        decHit    = 1'b1;
      end
    end
  end

  // Only the currently selected slave's ack and read data are looked at.
  always_comb begin
    ackHit   = |(bus.s_ack & sel_q);
    selRdata = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (sel_q[i]) begin
        selRdata = bus.s_rdata[i*DATA_W +: DATA_W];
      end
    end
    waitInc   = wait_q + CNT_W'(1);
    errCntInc = (errCnt_q == 8'hFF) ? errCnt_q : errCnt_q + 8'd1;
  end

  // Next-state and datapath update; ack is checked before the timeout so a
  // late ack on the final allowed cycle still completes normally.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    wait_d    = wait_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    errAddr_d = errAddr_q;
    errCnt_d  = errCnt_q;
    case (state_q)
      IDLE: begin
        if (bus.m_req) begin
          we_d    = bus.m_we;
          addr_d  = bus.m_addr;
          wdata_d = bus.m_wdata;
          wmask_d = bus.m_wmask;
          if (decHit) begin
            sel_d   = decSel;
            wait_d  = '0;
            state_d = BUSY;
          end else begin
            err_d     = 1'b1;
            rdata_d   = '0;
            errAddr_d = bus.m_addr;
            errCnt_d  = errCntInc;
            state_d   = RESP;
          end
        end
      end
      BUSY: begin
        if (ackHit) begin
          rdata_d = we_q ? '0 : selRdata;
          err_d   = 1'b0;
          sel_d   = '0;
          state_d = RESP;
        end else begin
          wait_d = waitInc;
          if ((TIMEOUT != 0) && (waitInc == TIMEOUT_LIM)) begin
            err_d     = 1'b1;
            rdata_d   = '0;
            sel_d     = '0;
            errAddr_d = addr_q;
            errCnt_d  = errCntInc;
            state_d   = RESP;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath, response and diagnostic registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      wait_q    <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      errAddr_q <= '0;
      errCnt_q  <= '0;
    end else begin
      sel_q     <= sel_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wmask_q   <= wmask_d;
      wait_q    <= wait_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      errAddr_q <= errAddr_d;
      errCnt_q  <= errCnt_d;
    end
  end

  assign bus.m_ready  = (state_q == IDLE);
  assign bus.m_rvalid = (state_q == RESP);
  assign bus.m_rdata  = rdata_q;
  assign bus.m_err    = err_q;
  assign bus.s_sel    = sel_q;
  assign bus.s_we     = we_q;
  assign bus.s_addr   = addr_q;
  assign bus.s_wdata  = wdata_q;
  assign bus.s_wmask  = wmask_q;
  assign bus.err_addr = errAddr_q;
  assign bus.err_cnt  = errCnt_q;

endmodule

// File: tb/tb_mmio_router.sv
// Directed bench for mmio_router with the default 8-slave map
// (slot i decodes ID i+1, IDs 0 and 9..F are unmapped) and TIMEOUT = 15.
module tb_mmio_router;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  logic [7:0]  fs;
  int          sc;
  int          ra;
  logic [31:0] rd;
  logic        er;
  int          rvCount;

  mmio_router_if #(.N_SLV(8), .DATA_W(32)) bus ();

  mmio_router #(
    .N_SLV(8), .DATA_W(32), .ID_LO(20), .ID_W(4),
    .SLV_ID(32'h87654321), .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one access once the router is ready and play the slave side:
  // 'noise' is driven on s_ack every waiting cycle, 'ackMask' is added during
  // cycle ackAt (cycle 1 = first cycle after the accept edge; 0 = never).
  // Reports the select seen in cycle 1, how many cycles s_sel was non-zero,
  // and the cycle in which m_rvalid appeared (-1 if it never did).
  task automatic applyStimulus(
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    input  logic [7:0]  noise,
    input  logic [7:0]  ackMask,
    input  int          ackAt,
    output logic [7:0]  firstSel,
    output int          selCycles,
    output int          rvalidAt,
    output logic [31:0] rdata,
    output logic        err
  );
    int  guard;
    bit  done;
    guard = 0;
    while (!bus.m_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("ready", {31'd0, bus.m_ready}, 32'd1);
    bus.m_req   = 1'b1;
    bus.m_we    = we;
    bus.m_addr  = addr;
    bus.m_wdata = wdata;
    bus.m_wmask = wmask;
    @(negedge clk);
    bus.m_req = 1'b0;
    firstSel  = bus.s_sel;
    selCycles = 0;
    rvalidAt  = -1;
    rdata     = '0;
    err       = 1'b0;
    done      = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      if (bus.s_sel != 8'd0) selCycles++;
      if (bus.m_rvalid) begin
        rvalidAt = c;
        rdata    = bus.m_rdata;
        err      = bus.m_err;
        done     = 1'b1;
      end else begin
        bus.s_ack = noise | ((c == ackAt) ? ackMask : 8'd0);
        @(negedge clk);
      end
    end
    bus.s_ack = 8'd0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst         = 1'b1;
    bus.m_req   = 1'b0;
    bus.m_we    = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
    bus.m_wmask = '0;
    bus.s_ack   = '0;
    for (int i = 0; i < 8; i++) bus.s_rdata[i*32 +: 32] = 32'hA5A5_0000 + 32'(i);
    bus.s_rdata[2*32 +: 32] = 32'hDEAD_BEEF;
    bus.s_rdata[6*32 +: 32] = 32'h0BAD_F00D;

    // Reset state.
    repeat (2) @(negedge clk);
    checkOutput("rst_ready",  {31'd0, bus.m_ready},  32'd1);
    checkOutput("rst_rvalid", {31'd0, bus.m_rvalid}, 32'd0);
    checkOutput("rst_sel",    {24'd0, bus.s_sel},    32'd0);
    checkOutput("rst_rdata",  bus.m_rdata,           32'd0);
    checkOutput("rst_err",    {31'd0, bus.m_err},    32'd0);
    checkOutput("rst_erradr", bus.err_addr,          32'd0);
    checkOutput("rst_errcnt", {24'd0, bus.err_cnt},  32'd0);
    checkOutput("rst_saddr",  bus.s_addr,            32'd0);
    checkOutput("rst_swe",    {31'd0, bus.s_we},     32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Read from slot 2 (ID 3), ack on the first BUSY cycle.
    applyStimulus(1'b0, 32'h0030_0010, 32'd0, 4'h0, 8'h00, 8'h04, 1, fs, sc, ra, rd, er);
    checkOutput("rd_sel",     {24'd0, fs},      32'h04);
    checkOutput("rd_selcyc",  32'(sc),          32'd1);
    checkOutput("rd_lat",     32'(ra),          32'd2);
    checkOutput("rd_data",    rd,               32'hDEAD_BEEF);
    checkOutput("rd_err",     {31'd0, er},      32'd0);
    checkOutput("rd_saddr",   bus.s_addr,       32'h0030_0010);
    @(negedge clk);
    checkOutput("rd_pulse",   {31'd0, bus.m_rvalid}, 32'd0);
    checkOutput("rd_hold",    bus.m_rdata,      32'hDEAD_BEEF);

    // Unmapped read (ID F).
    applyStimulus(1'b0, 32'h00F0_0000, 32'd0, 4'h0, 8'h00, 8'h00, 0, fs, sc, ra, rd, er);
    checkOutput("um_selcyc",  32'(sc),          32'd0);
    checkOutput("um_lat",     32'(ra),          32'd1);
    checkOutput("um_err",     {31'd0, er},      32'd1);
    checkOutput("um_data",    rd,               32'd0);
    checkOutput("um_erradr",  bus.err_addr,     32'h00F0_0000);
    checkOutput("um_errcnt",  {24'd0, bus.err_cnt}, 32'd1);

    // Write to slot 6 (ID 7), ack after four wait cycles.
    applyStimulus(1'b1, 32'h0070_0000, 32'h0000_005A, 4'b0001, 8'h00, 8'h40, 5, fs, sc, ra, rd, er);
    checkOutput("wr_sel",     {24'd0, fs},      32'h40);
    checkOutput("wr_selcyc",  32'(sc),          32'd5);
    checkOutput("wr_lat",     32'(ra),          32'd6);
    checkOutput("wr_data",    rd,               32'd0);
    checkOutput("wr_err",     {31'd0, er},      32'd0);
    checkOutput("wr_swe",     {31'd0, bus.s_we}, 32'd1);
    checkOutput("wr_swdata",  bus.s_wdata,      32'h0000_005A);
    checkOutput("wr_swmask",  {28'd0, bus.s_wmask}, 32'h1);
    checkOutput("wr_errcnt",  {24'd0, bus.err_cnt}, 32'd1);

    // Slot 2 never acks: 15 select cycles then a timeout error.
    applyStimulus(1'b0, 32'h0030_0040, 32'd0, 4'h0, 8'h00, 8'h00, 0, fs, sc, ra, rd, er);
    checkOutput("to_selcyc",  32'(sc),          32'd15);
    checkOutput("to_lat",     32'(ra),          32'd16);
    checkOutput("to_err",     {31'd0, er},      32'd1);
    checkOutput("to_data",    rd,               32'd0);
    checkOutput("to_erradr",  bus.err_addr,     32'h0030_0040);
    checkOutput("to_errcnt",  {24'd0, bus.err_cnt}, 32'd2);

    // The router accepts a fresh request after the timeout.
    applyStimulus(1'b0, 32'h0010_0000, 32'd0, 4'h0, 8'h00, 8'h01, 1, fs, sc, ra, rd, er);
    checkOutput("nx_sel",     {24'd0, fs},      32'h01);
    checkOutput("nx_lat",     32'(ra),          32'd2);
    checkOutput("nx_data",    rd,               32'hA5A5_0000);
    checkOutput("nx_err",     {31'd0, er},      32'd0);

    // Other slaves ack throughout; only slot 2's ack in cycle 3 counts.
    applyStimulus(1'b0, 32'h0030_0000, 32'd0, 4'h0, 8'hFB, 8'h04, 3, fs, sc, ra, rd, er);
    checkOutput("nz_selcyc",  32'(sc),          32'd3);
    checkOutput("nz_lat",     32'(ra),          32'd4);
    checkOutput("nz_data",    rd,               32'hDEAD_BEEF);
    checkOutput("nz_err",     {31'd0, er},      32'd0);

    // Ack lands on the same cycle the timeout would fire: success wins.
    applyStimulus(1'b0, 32'h0030_0000, 32'd0, 4'h0, 8'h00, 8'h04, 15, fs, sc, ra, rd, er);
    checkOutput("tie_selcyc", 32'(sc),          32'd15);
    checkOutput("tie_lat",    32'(ra),          32'd16);
    checkOutput("tie_err",    {31'd0, er},      32'd0);
    checkOutput("tie_data",   rd,               32'hDEAD_BEEF);
    checkOutput("tie_errcnt", {24'd0, bus.err_cnt}, 32'd2);

    // Reset while BUSY: select drops, access is discarded, diagnostics clear.
    @(negedge clk);
    bus.m_req  = 1'b1;
    bus.m_we   = 1'b0;
    bus.m_addr = 32'h0030_0000;
    @(negedge clk);
    bus.m_req = 1'b0;
    checkOutput("rb_sel",     {24'd0, bus.s_sel}, 32'h04);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rb_seloff",  {24'd0, bus.s_sel}, 32'd0);
    checkOutput("rb_errcnt",  {24'd0, bus.err_cnt}, 32'd0);
    checkOutput("rb_ready",   {31'd0, bus.m_ready}, 32'd1);
    // A stuck-high ack in IDLE must not produce anything either.
    bus.s_ack = 8'hFF;
    rvCount = 0;
    for (int c = 0; c < 4; c++) begin
      if (bus.m_rvalid) rvCount++;
      @(negedge clk);
    end
    bus.s_ack = 8'h00;
    checkOutput("rb_norvalid", 32'(rvCount),      32'd0);
    checkOutput("rb_idlesel",  {24'd0, bus.s_sel}, 32'd0);

    // 260 unmapped accesses saturate the error counter at 255.
    for (int k = 0; k < 260; k++) begin
      applyStimulus(1'b0, 32'h0000_0000 + 32'(k * 4), 32'd0, 4'h0, 8'h00, 8'h00, 0, fs, sc, ra, rd, er);
      if (k == 254) checkOutput("sat_254", {24'd0, bus.err_cnt}, 32'd255);
    end
    checkOutput("sat_errcnt", {24'd0, bus.err_cnt}, 32'd255);
    checkOutput("sat_erradr", bus.err_addr,         32'h0000_040C);
    checkOutput("sat_err",    {31'd0, er},          32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
